// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, redirect handling, IMem handshake and the IF/ID register.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h00400000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JalrTarget,
    input  logic        Stall_D,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemRdy,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        Valid_D,
    output logic        MisalignErr
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic TrapEn = 1'b1;
`else
    localparam logic TrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StFetch, StHold, StDiscard, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] target_q, target_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic        misalign;
    logic [31:0] raw_target;
    logic [31:0] target;

    always_comb begin
        redirect   = (PCSrc == 2'b01) || (PCSrc == 2'b11);
        raw_target = (PCSrc == 2'b11) ? (JalrTarget & ~32'd1) : BranchTarget;
        // Without the trap, bit1 is silently dropped rather than faulting.
        target     = {raw_target[31:2], raw_target[1] & TrapEn, raw_target[0]};
        misalign   = TrapEn & redirect & raw_target[1];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        target_d     = target_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pcplus4_d    = pcplus4_q;
        valid_d      = valid_q;
        misalign_d   = misalign_q;

        if (state_q != StHalt && misalign) begin
            state_d    = StHalt;
            misalign_d = 1'b1;
            valid_d    = 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (redirect) begin
                        valid_d = 1'b0;
                        if (IMemRdy) begin
                            addr_d = target;
                        end else begin
                            // Address must stay put until the outstanding beat completes.
                            target_d = target;
                            state_d  = StDiscard;
                        end
                    end else if (IMemRdy) begin
                        addr_d = addr_q + 32'd4;
                        if (!Stall_D) begin
                            instr_d   = IMemData;
                            pc_d      = addr_q;
                            pcplus4_d = addr_q + 32'd4;
                            valid_d   = 1'b1;
                        end else begin
                            skid_instr_d = IMemData;
                            skid_pc_d    = addr_q;
                            state_d      = StHold;
                        end
                    end else if (!Stall_D) begin
                        valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        valid_d = 1'b0;
                        addr_d  = target;
                        state_d = StFetch;
                    end else if (!Stall_D) begin
                        instr_d   = skid_instr_q;
                        pc_d      = skid_pc_q;
                        pcplus4_d = skid_pc_q + 32'd4;
                        valid_d   = 1'b1;
                        state_d   = StFetch;
                    end
                end
                StDiscard: begin
                    valid_d = 1'b0;
                    if (redirect) begin
                        target_d = target;
                    end
                    if (IMemRdy) begin
                        addr_d  = redirect ? target : target_q;
                        state_d = StFetch;
                    end
                end
                StHalt: begin
                    valid_d = 1'b0;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StFetch;
            addr_q       <= PC_RESET;
            target_q     <= PC_RESET;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'd0;
            pcplus4_q    <= 32'd0;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            target_q     <= target_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pcplus4_q    <= pcplus4_d;
            valid_q      <= valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign IMemReq     = !RESET && (state_q == StFetch || state_q == StDiscard);
    assign IMemAddr    = addr_q;
    assign Instr_D     = valid_q ? instr_q : NOP_INSTR;
    assign PC_D        = pc_q;
    assign PCPlus4_D   = pcplus4_q;
    assign Valid_D     = valid_q;
    assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns address ^ 0x12345678 unless overridden.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'h12345678;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] JalrTarget;
    logic        Stall_D;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemRdy;
    logic [31:0] IMemData;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PCPlus4_D;
    logic        Valid_D;
    logic        MisalignErr;

    logic        ovr_en;
    logic [31:0] ovr_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    assign IMemData = ovr_en ? ovr_data : (IMemAddr ^ KEY);

    fetch_unit dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .JalrTarget   (JalrTarget),
        .Stall_D      (Stall_D),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemRdy      (IMemRdy),
        .IMemData     (IMemData),
        .Instr_D      (Instr_D),
        .PC_D         (PC_D),
        .PCPlus4_D    (PCPlus4_D),
        .Valid_D      (Valid_D),
        .MisalignErr  (MisalignErr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET = 1'b1; PCSrc = 2'b00; BranchTarget = '0; JalrTarget = '0;
        Stall_D = 1'b0; IMemRdy = 1'b0; ovr_en = 1'b0; ovr_data = '0;

        // Reset state
        tick();
        chk("rst_req",      {31'd0, IMemReq},     32'd0);
        chk("rst_addr",     IMemAddr,             32'h00400000);
        chk("rst_valid",    {31'd0, Valid_D},     32'd0);
        chk("rst_instr",    Instr_D,              NOP);
        chk("rst_pc",       PC_D,                 32'd0);
        chk("rst_pcplus4",  PCPlus4_D,            32'd0);
        chk("rst_misalign", {31'd0, MisalignErr}, 32'd0);
        RESET = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, IMemReq}, 32'd1);

        // Zero-wait streaming
        IMemRdy = 1'b1;
        tick();
        chk("zw1_valid",   {31'd0, Valid_D}, 32'd1);
        chk("zw1_instr",   Instr_D,          32'h12745678);
        chk("zw1_pc",      PC_D,             32'h00400000);
        chk("zw1_pcplus4", PCPlus4_D,        32'h00400004);
        chk("zw1_addr",    IMemAddr,         32'h00400004);
        tick();
        chk("zw2_instr",   Instr_D,          32'h1274567C);
        chk("zw2_pc",      PC_D,             32'h00400004);
        chk("zw2_addr",    IMemAddr,         32'h00400008);

        // Branch during two wait states
        IMemRdy = 1'b0; PCSrc = 2'b01; BranchTarget = 32'h00400100;
        tick();
        chk("ws1_valid", {31'd0, Valid_D}, 32'd0);
        chk("ws1_addr",  IMemAddr,         32'h00400008);
        chk("ws1_req",   {31'd0, IMemReq}, 32'd1);
        PCSrc = 2'b00;
        tick();
        chk("ws2_valid", {31'd0, Valid_D}, 32'd0);
        chk("ws2_addr",  IMemAddr,         32'h00400008);
        IMemRdy = 1'b1;
        tick();
        chk("ws3_valid", {31'd0, Valid_D}, 32'd0);
        chk("ws3_addr",  IMemAddr,         32'h00400100);

        // Stall with skid buffer
        tick();
        chk("pre_stall_instr", Instr_D,  32'h12745778);
        chk("pre_stall_addr",  IMemAddr, 32'h00400104);
        ovr_en = 1'b1; ovr_data = 32'hDEADBEEF; Stall_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_instr", Instr_D,          32'h12745778);
            chk("hold_pc",    PC_D,             32'h00400100);
            chk("hold_valid", {31'd0, Valid_D}, 32'd1);
            chk("hold_req",   {31'd0, IMemReq}, 32'd0);
            chk("hold_addr",  IMemAddr,         32'h00400108);
        end
        ovr_en = 1'b0; Stall_D = 1'b0;
        tick();
        chk("unstall_instr",   Instr_D,          32'hDEADBEEF);
        chk("unstall_pc",      PC_D,             32'h00400104);
        chk("unstall_pcplus4", PCPlus4_D,        32'h00400108);
        chk("unstall_req",     {31'd0, IMemReq}, 32'd1);
        tick();
        chk("resume_instr", Instr_D,  32'h12745770);
        chk("resume_pc",    PC_D,     32'h00400108);
        chk("resume_addr",  IMemAddr, 32'h0040010C);

        // JALR while stalled: redirect overrides stall, bit0 cleared
        PCSrc = 2'b11; JalrTarget = 32'h00400011; Stall_D = 1'b1;
        tick();
        chk("jalr_valid", {31'd0, Valid_D}, 32'd0);
        chk("jalr_addr",  IMemAddr,         32'h00400010);
        PCSrc = 2'b00; Stall_D = 1'b0;

        // Address wrap
        PCSrc = 2'b01; BranchTarget = 32'hFFFFFFFC;
        tick();
        chk("wrap_addr0", IMemAddr, 32'hFFFFFFFC);
        PCSrc = 2'b00;
        tick();
        chk("wrap_pc",      PC_D,             32'hFFFFFFFC);
        chk("wrap_pcplus4", PCPlus4_D,        32'h00000000);
        chk("wrap_addr",    IMemAddr,         32'h00000000);
        chk("wrap_valid",   {31'd0, Valid_D}, 32'd1);

        // Misaligned JALR target
        PCSrc = 2'b11; JalrTarget = 32'h00400006;
        tick();
        PCSrc = 2'b00;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            chk("halt_err",   {31'd0, MisalignErr}, 32'd1);
            chk("halt_req",   {31'd0, IMemReq},     32'd0);
            chk("halt_valid", {31'd0, Valid_D},     32'd0);
            tick();
        end
`else
        chk("mis_addr",  IMemAddr,             32'h00400004);
        chk("mis_valid", {31'd0, Valid_D},     32'd0);
        chk("mis_err",   {31'd0, MisalignErr}, 32'd0);
        tick();
        chk("mis_instr", Instr_D, 32'h1274567C);
        chk("mis_pc",    PC_D,    32'h00400004);
`endif

        // Reset with a request outstanding
        IMemRdy = 1'b0; RESET = 1'b1;
        #1;
        chk("rst2_req_comb", {31'd0, IMemReq}, 32'd0);
        tick();
        chk("rst2_addr",  IMemAddr,             32'h00400000);
        chk("rst2_valid", {31'd0, Valid_D},     32'd0);
        chk("rst2_err",   {31'd0, MisalignErr}, 32'd0);
        chk("rst2_instr", Instr_D,              NOP);
        RESET = 1'b0;
        #1;
        chk("rst2_req", {31'd0, IMemReq}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
